// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the Intel8008 accumulator/flag stage.
//   src_e  : write source/mode encodings driven on SRC_I
//   cc_e   : condition-code flag select carried in COND_I[1:0]
//   CTX_W  : width of one saved context {A, C, Z, S, P}
//   ctx_t  : packed view of a saved context, MSB first = A
//   zsp_t  : result-derived zero/sign/parity flags
//   calcZsp: derives Z/S/P from an 8-bit result (P=1 means even parity)
package cpu_pkg;

  typedef enum logic [1:0] {
    SRC_ALU = 2'b00,
    SRC_ROT = 2'b01,
    SRC_MOV = 2'b10,
    SRC_CMP = 2'b11
  } src_e;

  typedef enum logic [1:0] {
    CC_C = 2'b00,
    CC_Z = 2'b01,
    CC_S = 2'b10,
    CC_P = 2'b11
  } cc_e;

  localparam int CTX_W = 12;

  // Field order fixes the bit layout of stack entries; CTX_W must match.
  typedef struct packed {
    logic [7:0] a;
    logic       c;
    logic       z;
    logic       s;
    logic       p;
  } ctx_t;

  typedef struct packed {
    logic z;
    logic s;
    logic p;
  } zsp_t;

  function automatic zsp_t calcZsp(input logic [7:0] d);
    zsp_t f;
    f.z = (d == 8'h00);
    f.s = d[7];
    f.p = ~^d;
    return f;
  endfunction

endpackage

// File: rtl/cpu_ctx_stack.sv
// cpu_ctx_stack
// LIFO save stack holding A+flags contexts for interrupt entry/exit.
// Ports:
//   CLK_I    in   core clock, rising edge
//   RST_I    in   synchronous active-high reset; clears pointer and error only
//   PUSH_I   in   save CTX_I on top of the stack
//   POP_I    in   remove the top entry (presented on TOP_O this cycle)
//   WE_I     in   accumulator write request, needed only to flag POP+WE
//   CTX_I    in   current {A,C,Z,S,P} to save
//   TOP_O    out  top-of-stack entry, valid when EMPTY_O=0
//   POP_OK_O out  a pop is accepted this cycle; the parent restores TOP_O
//   FULL_O   out  count == STK_DEPTH
//   EMPTY_O  out  count == 0
//   ERR_O    out  sticky error: overflow, underflow or conflicting requests
// STK_DEPTH must be a power of two between 2 and 8.
module cpu_ctx_stack
  import cpu_pkg::*;
#(
  parameter int unsigned STK_DEPTH = 4
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             PUSH_I,
  input  logic             POP_I,
  input  logic             WE_I,
  input  logic [CTX_W-1:0] CTX_I,
  output logic [CTX_W-1:0] TOP_O,
  output logic             POP_OK_O,
  output logic             FULL_O,
  output logic             EMPTY_O,
  output logic             ERR_O
);

  localparam int PTR_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [CTX_W-1:0] stackMem [STK_DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [PTR_W-1:0] wrPtr, topPtr;
  logic             pushOk, popOk, badReq;

  // The count carries one extra bit so that "full" is distinguishable from
  // "empty"; the low bits address the next free slot.
  assign FULL_O  = (count_q == CNT_W'(STK_DEPTH));
  assign EMPTY_O = (count_q == '0);
  assign wrPtr   = count_q[PTR_W-1:0];
  assign topPtr  = wrPtr - PTR_W'(1);
  assign TOP_O   = stackMem[topPtr];

  // PUSH and POP together cancel each other; an accepted pop also drops a
  // same-cycle write in the parent, which is reported as an error.
  assign pushOk   = PUSH_I & ~POP_I & ~FULL_O;
  assign popOk    = POP_I & ~PUSH_I & ~EMPTY_O;
  assign POP_OK_O = popOk;
  assign badReq   = (PUSH_I & POP_I) | (PUSH_I & FULL_O) |
                    (POP_I & EMPTY_O) | (POP_I & WE_I);

  // Pointer movement and sticky error accumulation.
  always_comb begin
    count_d = count_q;
    err_d   = err_q | badReq;
    if (pushOk) begin
      count_d = count_q + CNT_W'(1);
    end else if (popOk) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset; only the pointer is cleared, so stale entries are
  // unreachable after reset.
  always_ff @(posedge CLK_I) begin
    if (pushOk && !RST_I) begin
      stackMem[wrPtr] <= CTX_I;
    end
  end

  assign ERR_O = err_q;

endmodule

// File: rtl/cpu_acc_flag.sv
// cpu_acc_flag
// Accumulator and condition-flag register stage of the Intel8008 core.
// Commits rotator/ALU results into A and C/Z/S/P, feeds them back as the
// next operands, and evaluates jump/call/return conditions.
// Build option: define CPU_ACC_STACK_EN to include the A+flags save stack;
// without it PUSH_I/POP_I are ignored and the stack status outputs are tied.
// Ports:
//   CLK_I            in   core clock, rising edge
//   RST_I            in   synchronous active-high reset
//   WE_I             in   commit request, one cycle = one commit
//   SRC_I[1:0]       in   mode: ALU / ROT / MOV / CMP (see cpu_pkg)
//   D_I[7:0]         in   result data
//   C_I              in   carry from ALU/rotator
//   Z_I, S_I, P_I    in   rotator pass-through flags, not committed
//   COND_I[2:0]      in   {T, CC}: CT_O = (flag selected by CC) == T
//   PUSH_I, POP_I    in   save/restore A+flags
//   A_O[7:0]         out  accumulator
//   C_O,Z_O,S_O,P_O  out  flags
//   CT_O             out  condition true, combinational from registered flags
//   FULL_O, EMPTY_O  out  save-stack status
//   ERR_O            out  sticky stack error
module cpu_acc_flag
  import cpu_pkg::*;
#(
  parameter int unsigned STK_DEPTH = 4
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       WE_I,
  input  logic [1:0] SRC_I,
  input  logic [7:0] D_I,
  input  logic       C_I,
  input  logic       Z_I,
  input  logic       S_I,
  input  logic       P_I,
  input  logic [2:0] COND_I,
  input  logic       PUSH_I,
  input  logic       POP_I,
  output logic [7:0] A_O,
  output logic       C_O,
  output logic       Z_O,
  output logic       S_O,
  output logic       P_O,
  output logic       CT_O,
  output logic       FULL_O,
  output logic       EMPTY_O,
  output logic       ERR_O
);

  logic [7:0] a_q, a_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic       s_q, s_d;
  logic       p_q, p_d;

  zsp_t dZsp;
  ctx_t popCtx;
  logic popAccept;
  logic writeAllowed;
  logic selFlag;

  assign dZsp = calcZsp(D_I);

`ifdef CPU_ACC_STACK_EN
  ctx_t             curCtx;
  logic [CTX_W-1:0] topCtx;
  logic             unusedRotFlags;

  assign curCtx = '{a: a_q, c: c_q, z: z_q, s: s_q, p: p_q};

  cpu_ctx_stack #(
    .STK_DEPTH(STK_DEPTH)
  ) u_ctx_stack (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .PUSH_I   (PUSH_I),
    .POP_I    (POP_I),
    .WE_I     (WE_I),
    .CTX_I    (curCtx),
    .TOP_O    (topCtx),
    .POP_OK_O (popAccept),
    .FULL_O   (FULL_O),
    .EMPTY_O  (EMPTY_O),
    .ERR_O    (ERR_O)
  );

  assign popCtx = ctx_t'(topCtx);

  // Any POP request outranks a same-cycle write, even one that underflows.
  assign writeAllowed = WE_I & ~POP_I;

  // Rotator flags mirror our own registers and are never committed.
  assign unusedRotFlags = ^{Z_I, S_I, P_I};
`else
  logic unusedInputs;

  assign popAccept    = 1'b0;
  assign popCtx       = '0;
  assign writeAllowed = WE_I;
  assign FULL_O       = 1'b0;
  assign EMPTY_O      = 1'b1;
  assign ERR_O        = 1'b0;

  assign unusedInputs = ^{Z_I, S_I, P_I, PUSH_I, POP_I, STK_DEPTH[0]};
`endif

  // Next-state selection: a restored context beats a write; otherwise the
  // mode decides which of A and the flags a write touches.
  always_comb begin
    a_d = a_q;
    c_d = c_q;
    z_d = z_q;
    s_d = s_q;
    p_d = p_q;
    if (popAccept) begin
      a_d = popCtx.a;
      c_d = popCtx.c;
      z_d = popCtx.z;
      s_d = popCtx.s;
      p_d = popCtx.p;
    end else if (writeAllowed) begin
      case (src_e'(SRC_I))
        SRC_ALU: begin
          a_d = D_I;
          c_d = C_I;
          z_d = dZsp.z;
          s_d = dZsp.s;
          p_d = dZsp.p;
        end
        SRC_ROT: begin
          a_d = D_I;
          c_d = C_I;
        end
        SRC_MOV: begin
          a_d = D_I;
        end
        SRC_CMP: begin
          c_d = C_I;
          z_d = dZsp.z;
          s_d = dZsp.s;
          p_d = dZsp.p;
        end
        default: begin
        end
      endcase
    end
  end

  // Reset values describe A=0x00 with consistent Z=1 and even parity.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      a_q <= 8'h00;
      c_q <= 1'b0;
      z_q <= 1'b1;
      s_q <= 1'b0;
      p_q <= 1'b1;
    end else begin
      a_q <= a_d;
      c_q <= c_d;
      z_q <= z_d;
      s_q <= s_d;
      p_q <= p_d;
    end
  end

  // Condition select from registered flags only, so no write bypass exists.
  always_comb begin
    selFlag = c_q;
    case (cc_e'(COND_I[1:0]))
      CC_C:    selFlag = c_q;
      CC_Z:    selFlag = z_q;
      CC_S:    selFlag = s_q;
      CC_P:    selFlag = p_q;
      default: selFlag = c_q;
    endcase
  end

  assign CT_O = (selFlag == COND_I[2]);

  assign A_O = a_q;
  assign C_O = c_q;
  assign Z_O = z_q;
  assign S_O = s_q;
  assign P_O = p_q;

endmodule
